// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event decoder.
//   - FSM state encodings (also exported on the evt_state debug port)
//   - default timing parameters and counter width
package key_evt_pkg;

  localparam int unsigned LONG_CYC_DEF    = 100;
  localparam int unsigned DBL_GAP_CYC_DEF = 60;
  localparam int unsigned CNT_W           = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HOLD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } evt_state_e;

endpackage

// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns a debounced, active-low key level into
// short-click, long-press and double-click pulses.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   key_n        : debounced key level (0 = pressed)
//   short_press  : 1-cycle pulse, single short click
//   long_press   : 1-cycle pulse, hold reached LONG_CYC
//   double_click : 1-cycle pulse, two short presses within DBL_GAP_CYC
//   click_cnt    : running count of all events, wraps at 255
//   evt_state    : current FSM state (debug)
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_CYC    = LONG_CYC_DEF,
  parameter int unsigned DBL_GAP_CYC = DBL_GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic [7:0] click_cnt,
  output logic [2:0] evt_state
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);

  evt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_d_q;
  logic             arm_q;
  logic             short_q, long_q, dbl_q;
  logic             short_d, long_d, dbl_d;
  logic [7:0]       click_cnt_q;
  logic             fall, rise;

  // key_d resets to 1 and arm to 0, so a key held low across reset
  // release can never be mistaken for a fresh press.
  assign fall = key_d_q & ~key_n & arm_q;
  assign rise = ~key_d_q & key_n;

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      ST_IDLE:   if (fall) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (rise) state_d = ST_GAP;
        else if (!key_n && cnt_q == LONG_LAST) begin
          state_d = ST_HOLD;
          long_d  = 1'b1;
        end
      end
      ST_HOLD:   if (rise) state_d = ST_IDLE;
      ST_GAP: begin
        // a fall on the timeout cycle still counts as the second press
        if (fall) state_d = ST_PRESS2;
        else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (rise) begin
          state_d = ST_IDLE;
          dbl_d   = 1'b1;
        end else if (!key_n && cnt_q == LONG_LAST) begin
          // held second press still reports the double click, not a long press
          state_d = ST_HOLD;
          dbl_d   = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == ST_PRESS1 || state_q == ST_GAP || state_q == ST_PRESS2)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_d_q     <= 1'b1;
      arm_q       <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      dbl_q       <= 1'b0;
      click_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_d_q     <= key_n;
      arm_q       <= arm_q | key_n;
      short_q     <= short_d;
      long_q      <= long_d;
      dbl_q       <= dbl_d;
      // registered alongside the pulses so the count moves in the pulse cycle
      click_cnt_q <= click_cnt_q + {7'd0, short_d | long_d | dbl_d};
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign click_cnt    = click_cnt_q;
  assign evt_state    = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder (LONG_CYC=100, DBL_GAP_CYC=60).
// Expected events (kind, posedge index, click count) are queued when a
// gesture is driven; a negedge monitor pops and compares each pulse.
module tb_key_event_decoder;

  typedef struct {
    int         kind;   // 0 short, 1 long, 2 double
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b0;
  logic       short_press, long_press, double_click;
  logic [7:0] click_cnt;
  logic [2:0] evt_state;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_cnt = 8'd0;
  exp_t       q[$];

  key_event_decoder #(.LONG_CYC(100), .DBL_GAP_CYC(60)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .click_cnt    (click_cnt),
    .evt_state    (evt_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    int   nh;
    int   kind;
    exp_t e;
    if (rst_n) begin
      nh = int'(short_press) + int'(long_press) + int'(double_click);
      if (nh > 0) begin
        kind = short_press ? 0 : (long_press ? 1 : 2);
        checks++;
        if (nh > 1) begin
          failures++;
          $display("FAIL multi_pulse cyc=%0d pulses=%0d required=1", cyc, nh);
        end else if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_evt kind=%0d cyc=%0d required=none", kind, cyc);
        end else begin
          e = q.pop_front();
          if (kind !== e.kind || cyc !== e.cyc || click_cnt !== e.cnt) begin
            failures++;
            $display("FAIL evt kind=%0d cyc=%0d cnt=%0d required kind=%0d cyc=%0d cnt=%0d",
                     kind, cyc, click_cnt, e.kind, e.cyc, e.cnt);
          end
        end
      end
    end
  end

  task automatic expect_evt(input int kind, input int at);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.kind = kind; e.cyc = at; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  // Called at a negedge; first low level is sampled at posedge k.
  task automatic press(input int n, output int k);
    key_n = 1'b0;
    k = cyc + 1;
    repeat (n) @(negedge clk);
    key_n = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    checks++;
    if (evt_state !== exp) begin
      failures++;
      $display("FAIL %s evt_state=%0d required=%0d", name, evt_state, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events=%0d required=0", name, q.size());
      q.delete();
    end
    checks++;
    if (click_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL %s click_cnt=%0d required=%0d", name, click_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({short_press, long_press, double_click} !== 3'b000 || click_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs pulses=%b cnt=%0d required 000/0",
               {short_press, long_press, double_click}, click_cnt);
    end
    check_state("reset_state", 3'd0);
    rst_n = 1'b1;
    // filter still reports low after reset: must not look like a press
    repeat (3) begin
      @(negedge clk);
      check_state("post_reset_low", 3'd0);
    end
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("armed_idle", 3'd0);
    check_drained("reset");
  endtask

  task automatic test_short;
    int k;
    press(20, k);
    expect_evt(0, k + 80);
    check_state("short_in_press1", 3'd1);
    @(negedge clk);
    check_state("short_in_gap", 3'd3);
    repeat (100) @(negedge clk);
    check_state("short_idle", 3'd0);
    check_drained("short");
  endtask

  task automatic test_long;
    int k;
    key_n = 1'b0;
    k = cyc + 1;
    expect_evt(1, k + 100);
    repeat (150) @(negedge clk);
    check_state("long_hold", 3'd2);
    key_n = 1'b1;
    repeat (80) @(negedge clk);
    check_state("long_idle", 3'd0);
    check_drained("long");
  endtask

  task automatic test_double;
    int k1, k2;
    press(20, k1);
    repeat (30) @(negedge clk);
    press(20, k2);
    check_state("double_press2", 3'd4);
    expect_evt(2, k2 + 20);
    repeat (100) @(negedge clk);
    check_state("double_idle", 3'd0);
    check_drained("double");
  endtask

  task automatic test_gap_boundary;
    int k1, k2;
    // second fall exactly on the gap timeout cycle
    press(20, k1);
    repeat (60) @(negedge clk);
    press(20, k2);
    check_state("gap60_press2", 3'd4);
    expect_evt(2, k2 + 20);
    repeat (100) @(negedge clk);
    check_drained("gap60");
    // one cycle too late: short for the first press, new PRESS1
    press(20, k1);
    expect_evt(0, k1 + 80);
    repeat (61) @(negedge clk);
    press(20, k2);
    check_state("gap61_press1", 3'd1);
    expect_evt(0, k2 + 80);
    repeat (100) @(negedge clk);
    check_drained("gap61");
  endtask

  task automatic test_reset_mid;
    int k;
    key_n = 1'b0;
    k = cyc + 1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({short_press, long_press, double_click} !== 3'b000 || click_cnt !== 8'd0 ||
        evt_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_async pulses=%b cnt=%0d state=%0d required 000/0/0",
               {short_press, long_press, double_click}, click_cnt, evt_state);
    end
    exp_cnt = 8'd0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_state("reset_mid_held", 3'd0);
    key_n = 1'b1;
    repeat (100) @(negedge clk);
    check_state("reset_mid_idle", 3'd0);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 100, press-hold cycles to declare a long press (legal range 2..2^24-1).
REQ-002 SHALL have parameter DBL_GAP_CYC, default 60, maximum release-gap cycles for a second press to form a double click (legal range 2..2^24-1).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_n, input, 1, debounced key level from the key filter stage, synchronous to clk; 0 = pressed, 1 = released.
REQ-006 SHALL have port short_press, output, 1, one-cycle pulse for a single short click.
REQ-007 SHALL have port long_press, output, 1, one-cycle pulse when a hold reaches LONG_CYC.
REQ-008 SHALL have port double_click, output, 1, one-cycle pulse for two short presses within the gap.
REQ-009 SHALL have port click_cnt, output, 8, running count of all events (short, long, double), wraps 255->0.
REQ-010 SHALL have port evt_state, output, 3, current FSM state encoding, for debug.

Function
REQ-011 SHALL register key_n into key_d; fall = key_d & !key_n; rise = !key_d & key_n.
REQ-012 SHALL hold an arm flag, cleared by reset and set on the first cycle key_n=1; while unarmed, falls are ignored and the FSM stays IDLE.
REQ-013 SHALL implement states IDLE=0, PRESS1=1, HOLD=2, GAP=3, PRESS2=4; other codes return to IDLE next cycle.
REQ-014 SHALL use one 24-bit counter, cleared on every state change and incrementing every cycle in PRESS1, GAP and PRESS2.
REQ-015 IDLE: armed fall -> PRESS1.
REQ-016 PRESS1: cnt==LONG_CYC-1 with key still low -> HOLD, fire long_press; rise before that -> GAP.
REQ-017 HOLD: rise -> IDLE; no further events while held.
REQ-018 GAP: fall while cnt<DBL_GAP_CYC-1 -> PRESS2; cnt==DBL_GAP_CYC-1 with no fall -> IDLE, fire short_press.
REQ-019 PRESS2: rise -> IDLE, fire double_click; cnt==LONG_CYC-1 with no rise -> HOLD, fire double_click; long_press is never fired from PRESS2.
REQ-020 If a fall and a GAP timeout occur in the same cycle, the fall SHALL win (-> PRESS2, no short_press).
REQ-021 Event outputs SHALL be registered and high exactly one cycle, in the cycle after the clock edge at which the transition is taken; at most one event pulse per cycle.
REQ-022 click_cnt SHALL increment by 1 in the same cycle that any event pulse is high.
REQ-023 evt_state SHALL equal the registered current state with no added latency.

Reset
REQ-024 Assertion of rst_n=0 SHALL asynchronously force: state IDLE, counter 0, key_d=1, arm=0, short_press/long_press/double_click=0, click_cnt=0.
REQ-025 Reset mid-operation SHALL discard the gesture in progress without emitting any event; the post-reset low level from the filter SHALL NOT produce a fall.

Structure
REQ-026 State encodings and parameter defaults SHALL live in shared package key_evt_pkg.
REQ-027 SHALL be a single module with no sub-module; the filter-to-decoder connection sits in the top level.

Verification (LONG_CYC=100, DBL_GAP_CYC=60)
REQ-028 After reset, key_n=0 for 3 cycles then 1 permanently -> no event pulses, click_cnt=0, evt_state=0.
REQ-029 Press 20 cycles, release -> short_press once, 60 cycles after release is detected; click_cnt=1.
REQ-030 Press 150 cycles -> long_press on cycle 100 of the press; release -> no further pulse; state back to 0.
REQ-031 Press 20, release 30, press 20, release -> one double_click after the second rise; no short_press; click_cnt=1.
REQ-032 Second fall on the exact GAP timeout cycle -> PRESS2 taken and no short_press; a second fall at gap 61 -> short_press for the first press, then a new PRESS1.
REQ-033 rst_n pulsed low during PRESS1 at cycle 50 -> all outputs 0 immediately; no event after release.
